// File: rtl/spi_word_serializer.sv
// spi_word_serializer
//   Holds a WIDTH-bit word and presents it on bit_out one bit per shift_en strobe.
//   It sits between the register/sample source and the SPI slave MISO driver.
//   shift_en comes from the synchronised SCLK edge detector, and abort comes from
//   CS deassertion.
//
//   Optional feature macro: SERIALIZER_PARITY_EN
//     When defined, an even-parity bit (XOR of the captured word) follows the
//     last data bit, and done pulses on the shift of that parity bit.
//
//   Handshake: a word is transferred on a rising edge where load_valid && load_ready.
//     load_ready is combinational. It is high in IDLE. In ACTIVE it is high only on
//     the final-bit strobe, which allows back-to-back words with no gap.
//     When abort is high, any offered word is dropped, even if load_ready is high.
//
//   FSM state is mirrored on the registered busy output (busy == ACTIVE).
module spi_word_serializer #(
  parameter int   WIDTH      = 16,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             abort,
  output logic             bit_out,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic             last;

  // Bit presented for a given index of a word.
  // When parity is enabled, index WIDTH selects the parity bit.
  function automatic logic sel_bit(input logic [WIDTH-1:0] w, input logic [CNT_W-1:0] idx);
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] pos;
    pos     = (MSB_FIRST != 0) ? (LAST_POS - idx) : idx;
    sh      = w >> pos;
    sel_bit = sh[0];
`ifdef SERIALIZER_PARITY_EN
    if (idx == CNT_W'(WIDTH)) sel_bit = ^w;
`endif
  endfunction

  // Final bit of the word (or the parity bit) is currently on bit_out.
  assign last = (bit_idx == LAST_IDX);

  // Accept in IDLE, or on the last strobe of an active word.
  assign load_ready = (state == S_IDLE) ||
                      ((state == S_ACTIVE) && shift_en && last && !abort);

  // Word FSM: capture, shift, back-to-back reload, abort.
  // All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      word    <= '0;
      bit_idx <= '0;
      bit_out <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // CS released: discard the word. It is never resumed.
        state   <= S_IDLE;
        bit_idx <= '0;
        bit_out <= IDLE_LEVEL;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (load_valid) begin
              state   <= S_ACTIVE;
              word    <= data_in;
              bit_idx <= '0;
              bit_out <= sel_bit(data_in, '0);
              busy    <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (shift_en) begin
              if (last) begin
                done <= 1'b1;
                if (load_valid) begin
                  // Reload with no idle gap between words.
                  word    <= data_in;
                  bit_idx <= '0;
                  bit_out <= sel_bit(data_in, '0);
                end else begin
                  state   <= S_IDLE;
                  bit_idx <= '0;
                  bit_out <= IDLE_LEVEL;
                  busy    <= 1'b0;
                end
              end else begin
                bit_idx <= bit_idx + CNT_W'(1);
                bit_out <= sel_bit(word, bit_idx + CNT_W'(1));
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            bit_idx <= '0;
            bit_out <= IDLE_LEVEL;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_word_serializer.sv
// Bench for spi_word_serializer.
//   Two instances (MSB-first and LSB-first) share the same stimulus.
//   Expected bits are queued at load time and popped by a monitor at each strobe.
module tb_spi_word_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;
  logic         abort = 1'b0;

  logic         ready_m, bit_m, busy_m, done_m;
  logic         ready_l, bit_l, busy_l, done_l;
  logic [4:0]   idx_m, idx_l;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int done_seen = 0;
  bit in_word = 1'b0;

  logic [0:0] exp_m_q[$];
  logic [0:0] exp_l_q[$];

  spi_word_serializer #(.WIDTH(16), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .shift_en(shift_en), .abort(abort),
    .bit_out(bit_m), .bit_idx(idx_m), .busy(busy_m), .done(done_m)
  );

  spi_word_serializer #(.WIDTH(16), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .shift_en(shift_en), .abort(abort),
    .bit_out(bit_l), .bit_idx(idx_l), .busy(busy_l), .done(done_l)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference bit i of word w; index 16 is the even-parity bit.
  function automatic logic model(input logic [W-1:0] w, input int i, input bit msb);
    if (i == 16) return ^w;
    return msb ? w[15-i] : w[i];
  endfunction

  // Scoreboard monitor: the consumer takes bit_out at each strobe.
  always @(negedge clk) begin
    if (done_m) done_seen++;
    if (in_word && shift_en && !abort) begin
      if (exp_m_q.size() == 0) check("queue_m_underflow", 1, 0);
      else check("bit_out_msb", int'(bit_m), int'(exp_m_q.pop_front()));
      if (exp_l_q.size() == 0) check("queue_l_underflow", 1, 0);
      else check("bit_out_lsb", int'(bit_l), int'(exp_l_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < NBITS; i++) begin
      exp_m_q.push_back(model(w, i, 1'b1));
      exp_l_q.push_back(model(w, i, 1'b0));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy_m"}, int'(busy_m), 0);
    check({tag, "_busy_l"}, int'(busy_l), 0);
    check({tag, "_idx_m"}, int'(idx_m), 0);
    check({tag, "_bit_m"}, int'(bit_m), 0);
    check({tag, "_bit_l"}, int'(bit_l), 0);
  endtask

  // Offer a word from IDLE, then scramble data_in to show it is not re-sampled.
  task automatic load(input logic [W-1:0] w);
    data_in    = w;
    load_valid = 1'b1;
    #1;
    check("ready_idle", int'(ready_m), 1);
    push_word(w);
    in_word = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    data_in    = ~w;
    check("load_busy", int'(busy_m), 1);
    check("load_idx", int'(idx_m), 0);
    check("load_first_m", int'(bit_m), int'(model(w, 0, 1'b1)));
    check("load_first_l", int'(bit_l), int'(model(w, 0, 1'b0)));
  endtask

  // One strobe (strobe number k, 0-based) after gap idle cycles.
  task automatic strobe(input int k, input int gap);
    idle(gap);
    shift_en = 1'b1;
    #1;
    check("ready_strobe", int'(ready_m), (k == NBITS - 1) ? 1 : 0);
    @(posedge clk);
    #1;
    shift_en = 1'b0;
    if (k == NBITS - 1) begin
      in_word = 1'b0;
      exp_done++;
      check("done_last_m", int'(done_m), 1);
      check("done_last_l", int'(done_l), 1);
      check_idle("end");
      tick();
      check("done_one_cycle", int'(done_m), 0);
    end else begin
      check("done_mid", int'(done_m), 0);
      check("idx_mid", int'(idx_m), k + 1);
      check("busy_mid", int'(busy_m), 1);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    load(w);
    for (int k = 0; k < NBITS; k++) strobe(k, gap);
  endtask

  initial begin
    // Reset
    idle(3);
    rst = 1'b0;
    check_idle("reset");
    check("reset_done", int'(done_m), 0);

    // Tests 1 and 2: MSB-first and LSB-first serialisation of A53C, strobe every 4 clk.
    send_word(16'hA53C, 3);
    send_word(16'h3C5A, 1);

    // Test 5a: shift_en in IDLE is ignored.
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    check_idle("idle_shift");
    check("idle_shift_done", int'(done_m), 0);

    // Test 5b: load_valid while ACTIVE (not last) is refused.
    load(16'h1234);
    for (int k = 0; k < 3; k++) strobe(k, 1);
    load_valid = 1'b1;
    data_in    = 16'hFFFF;
    #1;
    check("ready_active_m", int'(ready_m), 0);
    check("ready_active_l", int'(ready_l), 0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("refused_idx", int'(idx_m), 3);
    check("refused_busy", int'(busy_m), 1);
    for (int k = 3; k < NBITS; k++) strobe(k, 2);

    // Test 3: back-to-back FFFF then 0001.
    load(16'hFFFF);
    for (int k = 0; k < NBITS - 1; k++) strobe(k, 0);
    shift_en   = 1'b1;
    load_valid = 1'b1;
    data_in    = 16'h0001;
    #1;
    check("b2b_ready_m", int'(ready_m), 1);
    check("b2b_ready_l", int'(ready_l), 1);
    @(posedge clk);
    #1;
    shift_en   = 1'b0;
    load_valid = 1'b0;
    data_in    = 16'h5555;
    exp_done++;
    push_word(16'h0001);
    check("b2b_done", int'(done_m), 1);
    check("b2b_busy", int'(busy_m), 1);
    check("b2b_idx", int'(idx_m), 0);
    check("b2b_first_m", int'(bit_m), 0);
    check("b2b_first_l", int'(bit_l), 1);
    for (int k = 0; k < NBITS; k++) strobe(k, 1);

    // Test 4: abort after 5 strobes; the offered word is ignored.
    load(16'hA53C);
    for (int k = 0; k < 5; k++) strobe(k, 1);
    abort      = 1'b1;
    load_valid = 1'b1;
    data_in    = 16'hFFFF;
    tick();
    abort      = 1'b0;
    load_valid = 1'b0;
    in_word    = 1'b0;
    exp_m_q.delete();
    exp_l_q.delete();
    check_idle("abort");
    check("abort_done", int'(done_m), 0);
    tick();
    check("abort_stays_idle", int'(busy_m), 0);
    send_word(16'h8000, 1);

    // Reset in the middle of a word gives reset values and no done pulse.
    load(16'hC3C3);
    for (int k = 0; k < 3; k++) strobe(k, 0);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    in_word = 1'b0;
    exp_m_q.delete();
    exp_l_q.delete();
    check_idle("midrst");
    check("midrst_done", int'(done_m), 0);

    // Test 6: parity on 0007 (parity bit 1 when enabled).
    send_word(16'h0007, 1);

    idle(3);
    check("done_count", done_seen, exp_done);
    check("queue_m_left", exp_m_q.size(), 0);
    check("queue_l_left", exp_l_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
